// File: rtl/ahb_slave_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_slave_mem_if
//  Description : AHB-Lite bus bundle between a master/interconnect and the
//                ahb_slave_mem responder.
//                master modport : drives HSEL, HADDR, HWRITE, HTRANS, HSIZE,
//                                 HBURST, HWDATA and the bus-level HREADY.
//                slave modport  : drives HRDATA, HREADYOUT, HRESP.
//  Revision    : 1.0  initial release
// ============================================================================
interface ahb_slave_mem_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface
`default_nettype wire

// File: rtl/ahb_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_slave_mem
//  Description : AHB-Lite responder backed by a word-organised memory.
//                Accepts NONSEQ/SEQ transfers, inserts WAIT_STATES wait
//                cycles per OKAY data phase, supports byte/halfword/word
//                writes with little-endian lanes, and answers illegal
//                transfers with a two-cycle ERROR response.
//  Ports       : Hclk  - bus clock (rising edge)
//                Hrst  - synchronous active-high reset
//                bus   - ahb_slave_mem_if.slave (address/control/data in,
//                        HRDATA/HREADYOUT/HRESP out)
//  Parameters  : MEM_WORDS   - number of 32-bit words (index = HADDR[31:2])
//                WAIT_STATES - wait cycles per OKAY data phase, 0..7
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_slave_mem #(
    parameter int MEM_WORDS   = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic             Hclk,
    input  logic             Hrst,
    ahb_slave_mem_if.slave   bus
);

    localparam int c_IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_hreadyout;
    logic                 r_hresp;
    logic [2:0]           r_cnt;
    logic [c_IDX_W+1:0]   r_addr;     // only the bits that select word and lane
    logic                 r_write;
    logic [2:0]           r_size;
    logic [31:0]          r_mem [MEM_WORDS];

    logic                 w_accept;
    logic                 w_take;
    logic                 w_err;
    logic                 w_oor;
    state_t               w_launch;
    state_t               w_next;
    logic [3:0]           w_be;
    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_unused;

    // HBURST carries no meaning for this responder.
    assign w_unused = ^bus.HBURST;

    assign w_accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];

    // A new address phase can only start where the previous data phase ends.
    assign w_take = w_accept &
                    ((r_state == S_IDLE) | (r_state == S_DATA) | (r_state == S_ERR2));

    assign w_oor = ({2'b00, bus.HADDR[31:2]} >= 32'(MEM_WORDS));
    assign w_err = w_oor
                 | (bus.HSIZE > 3'd2)
                 | ((bus.HSIZE == 3'd1) & bus.HADDR[0])
                 | ((bus.HSIZE == 3'd2) & (bus.HADDR[1:0] != 2'b00));

    assign w_launch = w_err             ? S_ERR1 :
                      (WAIT_STATES > 0) ? S_WAIT : S_DATA;

    assign w_idx = r_addr[c_IDX_W+1:2];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DATA, S_ERR2: w_next = w_take ? w_launch : S_IDLE;
            S_WAIT:                 w_next = (r_cnt <= 3'd1) ? S_DATA : S_WAIT;
            S_ERR1:                 w_next = S_ERR2;
            default:                w_next = S_IDLE;
        endcase
    end

    // Little-endian lane enables from the latched size and address.
    always_comb begin
        w_be = 4'b0000;
        case (r_size)
            3'd0:    w_be[r_addr[1:0]] = 1'b1;
            3'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hrst) begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_cnt       <= 3'd0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_size      <= 3'd0;
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            r_state     <= w_next;
            // Outputs are registered from the next state so they line up
            // with the state they describe.
            r_hreadyout <= !((w_next == S_WAIT) || (w_next == S_ERR1));
            r_hresp     <= (w_next == S_ERR1) || (w_next == S_ERR2);

            if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 3'd1;
            end

            if (w_take) begin
                r_addr  <= bus.HADDR[c_IDX_W+1:0];
                r_write <= bus.HWRITE;
                r_size  <= bus.HSIZE;
                r_cnt   <= 3'(WAIT_STATES);
            end

            // Write commits on the edge that ends the DATA cycle, so a read
            // pipelined right behind it sees the new value.
            if ((r_state == S_DATA) && r_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b]) begin
                        r_mem[w_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
                    end
                end
            end
        end
    end

    assign bus.HREADYOUT = r_hreadyout;
    assign bus.HRESP     = r_hresp;
    assign bus.HRDATA    = ((r_state == S_DATA) && !r_write) ? r_mem[w_idx] : 32'd0;

endmodule
`default_nettype wire
